// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- types and constants shared by the front-end stages.
//
//   XLEN           datapath / address width
//   NOP_INSTR      canonical RV32I NOP (addi x0, x0, 0) driven when idle
//   fetch_entry_t  one fetched instruction and the PC it was fetched from
//   word_align()   clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo -- DEPTH-entry synchronous FIFO of fetch entries.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   clear      drops every entry; wins over push and pop
//   push       write push_data at the tail (ignored when full and not popping)
//   push_data  entry to write
//   pop        remove the head entry (ignored when empty)
//   head       current head entry; contents undefined while empty
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//
// DEPTH must be a power of two so the pointers wrap for free.
// ---------------------------------------------------------------------------
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !clear && !empty;
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_push = push && !clear && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; count/pointers alone define which
  // entries are valid, and leaving it unreset lets it map onto plain RAM/flops
  // without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The producer is expected to respect the capacity; a write into a full,
  // non-draining FIFO would silently lose an instruction.
  push_into_full : assert property (
    @(posedge clk) disable iff (!rst) !(push && full && !pop && !clear)
  );

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue -- instruction prefetch unit between a ready/valid instruction
// memory and the IF/ID register.
//
// Issues sequential word fetches ahead of decode, buffers in-order responses
// in a fetch_fifo and presents one instruction per cycle with its PC. A
// redirect flushes the buffer and marks every outstanding request as stale so
// its response is discarded when it eventually returns.
//
// Parameters
//   DEPTH        queue entries; also the cap on outstanding + buffered words
//   RESET_PC     first fetch address after reset
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    fetch request valid
//   req_addr     word address of the request (bits [1:0] always 0)
//   req_ready    memory accepts the request
//   resp_valid   instruction word returned, in request order
//   resp_data    returned instruction
//   out_valid    out_pc/out_instr hold a valid instruction
//   out_pc       PC of out_instr (0 when idle)
//   out_instr    instruction (NOP when idle)
//   out_ready    pipeline consumes the head entry
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch PC; bits [1:0] ignored
//
// Build option
//   FETCH_QUEUE_BYPASS_EN  when defined and the queue is empty, a non-stale
//                          response is forwarded combinationally to out_*;
//                          if out_ready is high it is consumed and not pushed.
// ---------------------------------------------------------------------------
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            running;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   stale;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            empty;
  logic            issue;
  logic            resp_fire;
  logic            resp_keep;
  logic            bypass;
  logic            push;
  logic            pop;

  // ---------------------------------------------------------------- issue --
  // Every outstanding request (stale ones included) holds a queue slot, so a
  // returning word can always be pushed.
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign req_valid   = running && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign req_addr    = fetch_pc;
  assign issue       = req_valid && req_ready;

  // ------------------------------------------------------------- response --
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_fire = resp_valid && (inflight != '0);
  // During a redirect the arriving word belongs to the old stream.
  assign resp_keep = resp_fire && !redirect && (stale == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = resp_keep && empty;
`else
  assign bypass = 1'b0;
`endif

  assign push      = resp_keep && !(bypass && out_ready);
  assign pop       = out_ready && !empty && !redirect;
  assign push_data = '{pc: resp_pc, instr: resp_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  // -------------------------------------------------------------- outputs --
  // NOTE: every output gets a default before the if-chain so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = NOP_INSTR;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = head.pc;
      out_instr = head.instr;
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = resp_pc;
      out_instr = resp_data;
    end
  end

  // ------------------------------------------------- credit / stale / PCs --
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running  <= 1'b0;
      fetch_pc <= word_align(RESET_PC);
      resp_pc  <= word_align(RESET_PC);
      inflight <= '0;
      stale    <= '0;
    end else begin
      // Holds issue off until the first edge after reset release.
      running <= 1'b1;
      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
        resp_pc  <= word_align(redirect_pc);
        // No issue this cycle; everything still outstanding is now stale,
        // except a word returning right now, which is dropped immediately.
        inflight <= inflight - CW'(resp_fire);
        stale    <= inflight - CW'(resp_fire);
      end else begin
        if (issue)     fetch_pc <= fetch_pc + XLEN'(4);
        if (resp_keep) resp_pc  <= resp_pc + XLEN'(4);
        inflight <= inflight + CW'(issue) - CW'(resp_fire);
        if (resp_fire && (stale != '0)) stale <= stale - CW'(1);
      end
    end
  end

  req_addr_aligned : assert property (
    @(posedge clk) disable iff (!rst) req_addr[1:0] == 2'b00
  );

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue -- self-checking bench for fetch_queue.
//
// The reference model tracks the fetch stream as lists: outstanding requests
// (each with its PC and a flushed flag) and buffered {pc, instr} entries.
// Instruction memory contents are a fixed hash of the address, so every
// delivered instruction is checked against the PC it claims to come from.
// Build with +define+FETCH_QUEUE_BYPASS_EN to check the bypass variant.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit flushed; } pend_t;

  mreq_t        mem_q[$];   // memory side: accepted requests awaiting return
  pend_t        pend_q[$];  // model: requests the DUT should have outstanding
  fetch_entry_t buf_q[$];   // model: instructions the DUT should be holding

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          m_started = 1'b0;
  logic [31:0] m_fetch_pc = '0;

  // Observations from the most recent step.
  bit          seen_resp;
  bit          seen_acc;
  bit          seen_ov;
  logic [31:0] seen_addr;
  logic [31:0] seen_opc;
  logic [31:0] seen_oi;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit resp_due();
    return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
  endfunction

  // One clock cycle: drive inputs, compare every output against the model,
  // let memory react to the handshake, advance the model, then cross the edge.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit ordy, input bit qrdy);
    bit          resp_now;
    bit          e_rv;
    bit          e_ov;
    bit          byp;
    logic [31:0] e_pc;
    logic [31:0] e_in;
    pend_t       p;
    int          lat;
    resp_now    = resp_due();
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = ordy;
    req_ready   = qrdy;
    resp_valid  = resp_now;
    resp_data   = resp_now ? mem_word(mem_q[0].addr) : 32'($urandom());
    #1;
    e_rv = m_started && (buf_q.size() + pend_q.size() < DEPTH) && !rd;
    byp  = 1'b0;
    e_ov = 1'b0;
    e_pc = '0;
    e_in = NOP_INSTR;
    if (buf_q.size() > 0) begin
      e_ov = 1'b1;
      e_pc = buf_q[0].pc;
      e_in = buf_q[0].instr;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (!rd && resp_now && pend_q.size() > 0 && !pend_q[0].flushed) begin
      byp  = 1'b1;
      e_ov = 1'b1;
      e_pc = pend_q[0].pc;
      e_in = mem_word(pend_q[0].pc);
    end
`endif
    vectors += 5;
    if (req_valid !== e_rv) begin
      miscompares++;
      $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc, req_valid, e_rv);
    end
    if (req_addr !== m_fetch_pc) begin
      miscompares++;
      $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, req_addr, m_fetch_pc);
    end
    if (out_valid !== e_ov) begin
      miscompares++;
      $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, e_ov);
    end
    if (out_pc !== e_pc) begin
      miscompares++;
      $display("FAIL out_pc cyc=%0d got=%h want=%h", cyc, out_pc, e_pc);
    end
    if (out_instr !== e_in) begin
      miscompares++;
      $display("FAIL out_instr cyc=%0d got=%h want=%h", cyc, out_instr, e_in);
    end
    seen_resp = resp_now;
    seen_acc  = req_valid && req_ready;
    seen_addr = req_addr;
    seen_ov   = out_valid;
    seen_opc  = out_pc;
    seen_oi   = out_instr;
    // Memory: retire the returned word, accept a new request.
    if (resp_now) void'(mem_q.pop_front());
    if (req_valid && req_ready) begin
      lat = int'($urandom_range(lat_max, lat_min));
      mem_q.push_back('{req_addr, cyc + lat});
    end
    // Reference model.
    if (rd) begin
      buf_q.delete();
      foreach (pend_q[i]) pend_q[i].flushed = 1'b1;
      if (resp_now && pend_q.size() > 0) void'(pend_q.pop_front());
      m_fetch_pc = rpc & ~32'h3;
    end else begin
      if (e_ov && ordy && !byp) void'(buf_q.pop_front());
      if (resp_now && pend_q.size() > 0) begin
        p = pend_q.pop_front();
        if (!p.flushed && !(byp && ordy)) buf_q.push_back('{pc: p.pc, instr: mem_word(p.pc)});
      end
      if (e_rv && qrdy) begin
        pend_q.push_back('{m_fetch_pc, 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    m_started = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = '0;
    #1;
    vectors += 5;
    if (req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_valid got=%b want=0", req_valid);
    end
    if (req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_req_addr got=%h want=00000000", req_addr);
    end
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    if (out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out_pc got=%h want=00000000", out_pc);
    end
    if (out_instr !== 32'h13) begin
      miscompares++;
      $display("FAIL reset_out_instr got=%h want=00000013", out_instr);
    end
    mem_q.delete();
    pend_q.delete();
    buf_q.delete();
    m_started  = 1'b0;
    m_fetch_pc = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset_fetch();
    int first_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
    first_valid = 2;
`else
    first_valid = 3;
`endif
    lat_min = 1;
    lat_max = 1;
    test_reset();
    for (int i = 0; i < 24; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      vectors++;
      if (seen_ov !== (i >= first_valid)) begin
        miscompares++;
        $display("FAIL reset_fetch_valid_timing edge=%0d got=%b want=%b", i, seen_ov, i >= first_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int n;
    lat_min = 1;
    lat_max = 1;
    test_reset();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (seen_acc) acc++;
      if (seen_ov) begin
        vectors++;
        if (seen_opc !== 32'h0) begin
          miscompares++;
          $display("FAIL bp_frozen_pc got=%h want=00000000", seen_opc);
        end
      end
    end
    vectors++;
    if (acc != DEPTH) begin
      miscompares++;
      $display("FAIL bp_accepts got=%0d want=%0d", acc, DEPTH);
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      vectors++;
      if (!seen_ov || seen_opc !== 32'(n * 4)) begin
        miscompares++;
        $display("FAIL bp_drain valid=%b pc=%h want_pc=%h", seen_ov, seen_opc, 32'(n * 4));
      end
      n++;
    end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    lat_min = 3;
    lat_max = 3;
    test_reset();
    for (int i = 0; i < 20 && pend_q.size() != 2; i++) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (!seen_acc || seen_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL redir_first_req acc=%b addr=%h want_addr=00000100", seen_acc, seen_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      found = seen_ov;
    end
    vectors++;
    if (!found || seen_opc !== 32'h100 || seen_oi !== mem_word(32'h100)) begin
      miscompares++;
      $display("FAIL redir_first_out valid=%b pc=%h instr=%h want_pc=00000100 want_instr=%h",
               found, seen_opc, seen_oi, mem_word(32'h100));
    end
  endtask

  task automatic test_simultaneous();
    bit found;
    lat_min = 1;
    lat_max = 1;
    test_reset();
    for (int i = 0; i < 30 && !(buf_q.size() > 0 && resp_due()); i++) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      found = seen_ov;
    end
    vectors++;
    if (!found || seen_opc !== 32'h200) begin
      miscompares++;
      $display("FAIL simul_first_out valid=%b pc=%h want_pc=00000200", found, seen_opc);
    end
  endtask

  task automatic test_back_to_back();
    int          bad;
    bit          found;
    logic [31:0] first_pc;
    lat_min = 1;
    lat_max = 3;
    test_reset();
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h40, 1'b1, 1'b1);
    step(1'b1, 32'h80, 1'b1, 1'b1);
    bad      = 0;
    found    = 1'b0;
    first_pc = '0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      if (seen_ov && seen_opc >= 32'h40 && seen_opc < 32'h80) bad++;
      if (seen_ov && !found) begin
        found    = 1'b1;
        first_pc = seen_opc;
      end
    end
    vectors += 2;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL b2b_old_target got=%0d instructions want=0", bad);
    end
    if (!found || first_pc !== 32'h80) begin
      miscompares++;
      $display("FAIL b2b_first_out valid=%b pc=%h want_pc=00000080", found, first_pc);
    end
  endtask

  task automatic test_wrap_bypass();
    logic [31:0] addrs[2];
    int          na;
    bit          found;
    bit          want_ov;
    bit          cand;
`ifdef FETCH_QUEUE_BYPASS_EN
    want_ov = 1'b1;
`else
    want_ov = 1'b0;
`endif
    lat_min = 1;
    lat_max = 1;
    test_reset();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b1);
    // Low bits set on purpose: they must be ignored.
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    na    = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cand = buf_q.size() == 0 && resp_due() && pend_q.size() > 0 && !pend_q[0].flushed;
      step(1'b0, '0, 1'b1, 1'b1);
      if (seen_acc && na < 2) begin
        addrs[na] = seen_addr;
        na++;
      end
      if (cand && !found) begin
        found = 1'b1;
        vectors++;
        if (seen_ov !== want_ov) begin
          miscompares++;
          $display("FAIL bypass_same_cycle got=%b want=%b", seen_ov, want_ov);
        end
      end
    end
    vectors += 2;
    if (na < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_addrs n=%0d a0=%h a1=%h want=fffffffc,00000000", na, addrs[0], addrs[1]);
    end
    if (!found) begin
      miscompares++;
      $display("FAIL bypass_window got=none want=empty-queue response");
    end
  endtask

  task automatic test_random();
    lat_min = 1;
    lat_max = 5;
    test_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99, 0) < 5, 32'($urandom()),
           $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 75);
      if (i == 300) test_reset();
    end
  endtask

  initial begin
    test_reset_fetch();
    test_backpressure();
    test_redirect_inflight();
    test_simultaneous();
    test_back_to_back();
    test_wrap_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not finish");
  end

endmodule
